// File: rtl/gpio_pkg.sv
// Constants shared by the GPIO peripheral and its button
// input conditioning stage.
package gpio_pkg;

  localparam int GPIO_WIDTH       = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/debounce_bit.sv
// One button channel: two-flop synchroniser, stability
// counter, accepted level and registered edge pulses.
module debounce_bit #(
  parameter int   CNT_WIDTH       = 16,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic button_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_stable;
  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_diff;
  logic w_accept;

  assign w_diff   = r_sync2 != r_stable;
  assign w_accept = w_diff && (r_cnt == LP_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1  <= IDLE_LEVEL;
      r_sync2  <= IDLE_LEVEL;
      r_stable <= IDLE_LEVEL;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1 <= button_i;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        // pulses land with the first cycle button_o shows r_sync2
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_rise   <= r_sync2;
        r_fall   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign button_o = r_stable;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;

endmodule

// File: rtl/button_debounce.sv
// Button conditioning ahead of GPIO: per-bit debounce,
// sticky rise events and a masked, registered interrupt.
module button_debounce
  import gpio_pkg::*;
#(
  parameter int               WIDTH           = GPIO_WIDTH,
  parameter int               CNT_WIDTH       = 16,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] button_i,
  output logic [WIDTH-1:0] button_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] event_o,
  input  logic [WIDTH-1:0] clr_i,
  input  logic [WIDTH-1:0] irq_en_i,
  output logic             irq_o
);

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] r_event;
  logic             r_irq;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL[g])
    ) u_bit (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .button_i(button_i[g]),
      .button_o(button_o[g]),
      .rise_o  (w_rise[g]),
      .fall_o  (fall_o[g])
    );
  end

  // a rise in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_event <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_event <= (r_event & ~clr_i) | w_rise;
      r_irq   <= |(r_event & irq_en_i);
    end
  end

  assign rise_o  = w_rise;
  assign event_o = r_event;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random
// bouncing inputs against a sample-window reference model.
module tb_button_debounce;
  import gpio_pkg::*;

  localparam int W = GPIO_WIDTH;
  localparam int D = DEBOUNCE_SIM;
  localparam logic [W-1:0] IDLE = '0;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] button;
  logic [W-1:0] clr;
  logic [W-1:0] irq_en;
  logic [W-1:0] button_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] event_o;
  logic         irq_o;

  always #5 clk = ~clk;

  button_debounce #(
    .WIDTH          (W),
    .CNT_WIDTH      (16),
    .DEBOUNCE_CYCLES(D),
    .IDLE_LEVEL     (IDLE)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .button_i(button),
    .button_o(button_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .event_o (event_o),
    .clr_i   (clr),
    .irq_en_i(irq_en),
    .irq_o   (irq_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_stable;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] m_event;
  logic         m_irq;
  logic [W-1:0] pipe[$];
  logic [W-1:0] hist[$];

  // A bit flips when its last D synchronised samples all
  // disagree with the accepted level.
  task automatic model_edge();
    logic [W-1:0] v, flip, ev_old, rise_old;
    if (rst) begin
      m_stable = IDLE;
      m_rise   = '0;
      m_fall   = '0;
      m_event  = '0;
      m_irq    = 1'b0;
      pipe     = {IDLE, IDLE};
      hist     = {};
    end else begin
      ev_old   = m_event;
      rise_old = m_rise;
      v = pipe.pop_front();
      pipe.push_back(button);
      hist.push_back(v);
      if (hist.size() > D) void'(hist.pop_front());
      flip = '0;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          flip[b] = 1'b1;
          foreach (hist[k])
            if (hist[k][b] == m_stable[b]) flip[b] = 1'b0;
        end
      end
      m_rise   = flip & ~m_stable;
      m_fall   = flip & m_stable;
      m_stable = m_stable ^ flip;
      m_irq    = |(ev_old & irq_en);
      m_event  = (ev_old & ~clr) | rise_old;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button = '0;
    clr = '0;
    irq_en = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({button_o, rise_o, fall_o, event_o, irq_o} !== '0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%b exp=0", c,
                 {button_o, rise_o, fall_o, event_o, irq_o});
      end
    end
  endtask

  task automatic test_press();
    button[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (button_o[0] !== (e >= 6) || rise_o[0] !== (e == 6)) begin
        failures++;
        $display("FAIL press e=%0d got btn=%b rise=%b exp btn=%b rise=%b",
                 e, button_o[0], rise_o[0], e >= 6, e == 6);
      end
    end
    checks++;
    if (event_o !== 4'b0001) begin
      failures++;
      $display("FAIL press_event got=%b exp=0001", event_o);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] seq = 10'b1110011100;
    for (int i = 0; i < 10; i++) begin
      button[1] = seq[9-i];
      tick();
      checks++;
      if (button_o[1] !== 1'b0 || rise_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL bounce i=%0d got btn=%b rise=%b exp 0",
                 i, button_o[1], rise_o[1]);
      end
    end
    button[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (button_o[1] !== (e >= 6) || rise_o[1] !== (e == 6)) begin
        failures++;
        $display("FAIL bounce_hold e=%0d got btn=%b rise=%b",
                 e, button_o[1], rise_o[1]);
      end
    end
  endtask

  task automatic test_release();
    button[2] = 1'b1;
    repeat (8) tick();
    button[2] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (button_o[2] !== (e < 6) || fall_o[2] !== (e == 6) ||
          event_o[2] !== 1'b1) begin
        failures++;
        $display("FAIL release e=%0d got btn=%b fall=%b ev=%b",
                 e, button_o[2], fall_o[2], event_o[2]);
      end
    end
  endtask

  task automatic test_collision();
    bit seen = 0;
    button[3] = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (rise_o[3] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL collision_rise got=none exp=pulse");
    end
    clr[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    checks++;
    if (event_o[3] !== 1'b1) begin
      failures++;
      $display("FAIL collision_set got=%b exp=1", event_o[3]);
    end
    tick();
    clr[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    checks++;
    if (event_o[3] !== 1'b0) begin
      failures++;
      $display("FAIL collision_clr got=%b exp=0", event_o[3]);
    end
  endtask

  task automatic test_irq();
    bit seen = 0;
    clr = '1;
    button[0] = 1'b0;
    tick();
    clr = '0;
    repeat (8) tick();
    irq_en = 4'b0001;
    button[0] = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (event_o[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_lag seen=%0d got irq=%b exp=0", seen, irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin
      failures++;
      $display("FAIL irq_set got=%b exp=1", irq_o);
    end
    irq_en = '0;
    tick();
    checks++;
    if (irq_o !== 1'b0 || event_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL irq_mask got irq=%b ev=%b exp irq=0 ev=1",
               irq_o, event_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    button = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    button = 4'b0001;
    repeat (4) tick();
    rst = 1'b1;
    button = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (button_o !== IDLE || rise_o !== '0) begin
        failures++;
        $display("FAIL reset_mid c=%0d got btn=%b rise=%b exp 0",
                 c, button_o, rise_o);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(5) == 0) button[b] = ~button[b];
      for (int b = 0; b < W; b++)
        clr[b] = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) irq_en = W'($urandom);
      rst = ($urandom_range(199) == 0);
      tick();
      checks++;
      if ({button_o, rise_o, fall_o, event_o, irq_o} !==
          {m_stable, m_rise, m_fall, m_event, m_irq}) begin
        failures++;
        $display("FAIL random c=%0d got=%b exp=%b", c,
                 {button_o, rise_o, fall_o, event_o, irq_o},
                 {m_stable, m_rise, m_fall, m_event, m_irq});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_collision();
    test_irq();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
